firebird7_in_gate1_tessent_data_mux_ctrl: RTL and testbench

//  IJTAG-side controller for a W-bit ijtag/functional data mux: owns the mux select and the override data.

---
 rtl/firebird7_in_gate1_data_mux_ctrl_pkg.sv | 22 ++
 rtl/firebird7_in_gate1_data_mux_ctrl_tdr.sv | 48 ++++
 rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv | 156 +++++++++++++++
 tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate1_data_mux_ctrl_pkg.sv
// Shared types and helpers for the IJTAG data-mux controller.
//   state_e    : takeover/release sequencer states
//   cnt_width  : width of the shared settle/timeout counter
package firebird7_in_gate1_data_mux_ctrl_pkg;

  typedef enum logic [2:0] {
    StFunc,
    StQreq,
    StSettleIn,
    StTest,
    StRelease
  } state_e;

  // One spare bit above the largest terminal count so the counter can saturate, never wrap.
  function automatic int unsigned cnt_width(input int unsigned settle,
                                            input int unsigned timeout);
    int unsigned m;
    m = (settle > timeout) ? settle : timeout;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_data_mux_ctrl_tdr.sv
// Capture/shift/update test data register, WIDTH+1 bits: {enable, data[WIDTH-1:0]}.
// Ports:
//   i_clk, i_rst        tck and asynchronous active-high reset
//   i_sel               segment selected; all TDR operations gated by it
//   i_ce, i_se, i_ue    capture / shift / update enables (priority ce > se > ue)
//   i_si                scan in
//   i_test              sequencer is in TEST, captured into the enable bit
//   i_capture_data      functional data captured into the data bits
//   o_so                scan out (shift register LSB)
//   o_upd               update register
module firebird7_in_gate1_data_mux_ctrl_tdr #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sel,
  input  logic             i_ce,
  input  logic             i_se,
  input  logic             i_ue,
  input  logic             i_si,
  input  logic             i_test,
  input  logic [WIDTH-1:0] i_capture_data,
  output logic             o_so,
  output logic [WIDTH:0]   o_upd
);

  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] r_upd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_upd   <= '0;
    end else if (i_sel) begin
      if (i_ce) begin
        r_shift <= {i_test, i_capture_data};
      end else if (i_se) begin
        r_shift <= {i_si, r_shift[WIDTH:1]};
      end else if (i_ue) begin
        r_upd <= r_shift;
      end
    end
  end

  assign o_so  = r_shift[0];
  assign o_upd = r_upd;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// IJTAG-side owner of a functional/ijtag data mux. A TDR {enable, data} requests takeover; the
// sequencer quiesces the functional owner (req/ack), waits SETTLE_CYCLES, then selects ijtag data.
// Release walks the same steps backwards so the mux never switches under live traffic.
// Ports:
//   ijtag_tck, ijtag_reset        clock and asynchronous active-high reset
//   ijtag_sel/ce/se/ue/si/so      IJTAG segment access
//   functional_data_in            functional value observed on capture
//   func_quiesce_ack/req          quiesce handshake with the functional owner
//   ijtag_select                  mux select (1 = ijtag data)
//   ijtag_data_out                override data
//   takeover_error                sticky: ack timeout or ack lost while selected
module firebird7_in_gate1_tessent_data_mux_ctrl
  import firebird7_in_gate1_data_mux_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = 3,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  input  logic             func_quiesce_ack,
  output logic             func_quiesce_req,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             takeover_error
);

  localparam int unsigned      CntW       = cnt_width(SETTLE_CYCLES, ACK_TIMEOUT);
  localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0]  AckLast    = CntW'(ACK_TIMEOUT - 1);
  localparam logic [CntW-1:0]  CntMax     = '1;

  logic [WIDTH:0]  w_upd;
  logic            w_upd_en;
  state_e          r_state;
  state_e          w_state_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic            w_cnt_inc;
  logic            r_err;
  logic            w_err_next;
  logic            r_req;
  logic            r_sel;

  firebird7_in_gate1_data_mux_ctrl_tdr #(
    .WIDTH (WIDTH)
  ) u_tdr (
    .i_clk          (ijtag_tck),
    .i_rst          (ijtag_reset),
    .i_sel          (ijtag_sel),
    .i_ce           (ijtag_ce),
    .i_se           (ijtag_se),
    .i_ue           (ijtag_ue),
    .i_si           (ijtag_si),
    .i_test         (r_state == StTest),
    .i_capture_data (functional_data_in),
    .o_so           (ijtag_so),
    .o_upd          (w_upd)
  );

  assign w_upd_en = w_upd[WIDTH];

  always_comb begin
    w_state_next = r_state;
    w_cnt_inc    = 1'b0;
    w_err_next   = r_err;
    unique case (r_state)
      StFunc: begin
        if (w_upd_en) begin
          w_state_next = StQreq;
          w_err_next   = 1'b0;
        end
      end
      StQreq: begin
        if (!w_upd_en) begin
          w_state_next = StFunc;
        end else if (func_quiesce_ack) begin
          w_state_next = StSettleIn;
        end else if (r_cnt == AckLast) begin
          w_state_next = StFunc;
          w_err_next   = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      StSettleIn: begin
        if (!w_upd_en) begin
          w_state_next = StRelease;
        end else if (r_cnt == SettleLast) begin
          w_state_next = StTest;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      StTest: begin
        // Losing ack while selected is flagged but the mux is not yanked back.
        if (!func_quiesce_ack) begin
          w_err_next = 1'b1;
        end
        if (!w_upd_en) begin
          w_state_next = StRelease;
        end
      end
      StRelease: begin
        // A fresh enable is deliberately ignored here; FUNC picks it up afterwards.
        if (r_cnt == SettleLast) begin
          w_state_next = StFunc;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: begin
        w_state_next = StFunc;
      end
    endcase
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_state_next != r_state) begin
      w_cnt_next = '0;
    end else if (w_cnt_inc && (r_cnt != CntMax)) begin
      w_cnt_next = r_cnt + CntW'(1);
    end
  end

  // Outputs are flops loaded from the next state so they switch on the same edge as the state.
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_state <= StFunc;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      r_req   <= (w_state_next != StFunc);
      r_sel   <= (w_state_next == StTest);
    end
  end

  assign func_quiesce_req = r_req;
  assign ijtag_select     = r_sel;
  assign takeover_error   = r_err;
  assign ijtag_data_out   = w_upd[WIDTH-1:0];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

  localparam int unsigned WIDTH = 3;

  localparam int SigSo   = 0;
  localparam int SigReq  = 1;
  localparam int SigSel  = 2;
  localparam int SigData = 3;
  localparam int SigErr  = 4;

  typedef struct {
    string      name;
    int         sig;
    logic [7:0] exp;
  } chk_t;

  logic             ijtag_tck;
  logic             ijtag_reset;
  logic             ijtag_sel;
  logic             ijtag_ce;
  logic             ijtag_se;
  logic             ijtag_ue;
  logic             ijtag_si;
  logic             ijtag_so;
  logic [WIDTH-1:0] functional_data_in;
  logic             func_quiesce_ack;
  logic             func_quiesce_req;
  logic             ijtag_select;
  logic [WIDTH-1:0] ijtag_data_out;
  logic             takeover_error;

  chk_t       q[$];
  chk_t       m_item;
  logic [7:0] m_act;
  int         n_checks = 0;
  int         n_errors = 0;

  firebird7_in_gate1_tessent_data_mux_ctrl #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (4),
    .ACK_TIMEOUT   (8)
  ) dut (
    .ijtag_tck          (ijtag_tck),
    .ijtag_reset        (ijtag_reset),
    .ijtag_sel          (ijtag_sel),
    .ijtag_ce           (ijtag_ce),
    .ijtag_se           (ijtag_se),
    .ijtag_ue           (ijtag_ue),
    .ijtag_si           (ijtag_si),
    .ijtag_so           (ijtag_so),
    .functional_data_in (functional_data_in),
    .func_quiesce_ack   (func_quiesce_ack),
    .func_quiesce_req   (func_quiesce_req),
    .ijtag_select       (ijtag_select),
    .ijtag_data_out     (ijtag_data_out),
    .takeover_error     (takeover_error)
  );

  initial ijtag_tck = 1'b0;
  always #5 ijtag_tck = ~ijtag_tck;

  function automatic logic [7:0] get_sig(input int sig);
    case (sig)
      SigSo:   return {7'd0, ijtag_so};
      SigReq:  return {7'd0, func_quiesce_req};
      SigSel:  return {7'd0, ijtag_select};
      SigData: return {5'd0, ijtag_data_out};
      default: return {7'd0, takeover_error};
    endcase
  endfunction

  always @(negedge ijtag_tck) begin
    while (q.size() > 0) begin
      m_item   = q.pop_front();
      m_act    = get_sig(m_item.sig);
      n_checks = n_checks + 1;
      if (m_act !== m_item.exp) begin
        n_errors = n_errors + 1;
        $display("FAIL %s: got %0d expected %0d", m_item.name, m_act, m_item.exp);
      end
    end
  end

  task automatic chk(input string name, input int sig, input logic [7:0] exp);
    q.push_back('{name, sig, exp});
  endtask

  task automatic step();
    @(posedge ijtag_tck);
    #1;
  endtask

  task automatic capture();
    ijtag_ce = 1'b1;
    step();
    ijtag_ce = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    ijtag_se = 1'b1;
    ijtag_si = b;
    step();
    ijtag_se = 1'b0;
  endtask

  task automatic shift_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      shift_bit(w[i]);
    end
  endtask

  task automatic update();
    ijtag_ue = 1'b1;
    step();
    ijtag_ue = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_so"},   SigSo,   8'd0);
    chk({tag, "_req"},  SigReq,  8'd0);
    chk({tag, "_sel"},  SigSel,  8'd0);
    chk({tag, "_data"}, SigData, 8'd0);
    chk({tag, "_err"},  SigErr,  8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ijtag_reset        = 1'b1;
    ijtag_sel          = 1'b0;
    ijtag_ce           = 1'b0;
    ijtag_se           = 1'b0;
    ijtag_ue           = 1'b0;
    ijtag_si           = 1'b0;
    functional_data_in = '0;
    func_quiesce_ack   = 1'b0;
    #1;
    chk_all_zero("reset");
    step();
    step();
    ijtag_reset = 1'b0;

    ijtag_sel          = 1'b1;
    functional_data_in = 3'b101;
    capture();
    chk("cap_so", SigSo, 8'd1);
    shift_bit(1'b1); chk("sh1_so", SigSo, 8'd0);
    shift_bit(1'b0); chk("sh2_so", SigSo, 8'd1);
    shift_bit(1'b1); chk("sh3_so", SigSo, 8'd0);
    shift_bit(1'b1); chk("sh4_so", SigSo, 8'd1);
    update();
    chk("upd_data", SigData, 8'd5);
    chk("upd_req", SigReq, 8'd0);

    step();
    chk("qreq_req", SigReq, 8'd1);
    chk("qreq_sel", SigSel, 8'd0);
    step();
    step();
    chk("qreq_wait_sel", SigSel, 8'd0);
    func_quiesce_ack = 1'b1;
    step();
    chk("settle0_sel", SigSel, 8'd0);
    step();
    step();
    step();
    chk("settle3_sel", SigSel, 8'd0);
    step();
    chk("test_sel", SigSel, 8'd1);
    chk("test_req", SigReq, 8'd1);

    functional_data_in = 3'b010;
    capture();
    chk("tcap_so", SigSo, 8'd0);
    shift_bit(1'b0); chk("tsh1_so", SigSo, 8'd1);
    shift_bit(1'b0); chk("tsh2_so", SigSo, 8'd0);
    shift_bit(1'b0); chk("tcap_bit3", SigSo, 8'd1);

    update();
    chk("rel_upd_data", SigData, 8'd1);
    chk("rel_upd_sel", SigSel, 8'd1);
    step();
    chk("rel_sel", SigSel, 8'd0);
    chk("rel_req", SigReq, 8'd1);
    func_quiesce_ack = 1'b0;
    step();
    step();
    step();
    chk("rel3_req", SigReq, 8'd1);
    step();
    chk("rel_done_req", SigReq, 8'd0);
    chk("rel_done_err", SigErr, 8'd0);

    shift_word(4'b1110);
    update();
    chk("to_upd_data", SigData, 8'd6);
    chk("to_upd_req", SigReq, 8'd0);
    step();
    chk("to_qreq_req", SigReq, 8'd1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("to_wait_sel", SigSel, 8'd0);
      chk("to_wait_req", SigReq, 8'd1);
      chk("to_wait_err", SigErr, 8'd0);
    end
    step();
    chk("to_abort_req", SigReq, 8'd0);
    chk("to_abort_err", SigErr, 8'd1);
    chk("to_abort_sel", SigSel, 8'd0);
    step();
    chk("to_reen_req", SigReq, 8'd1);
    chk("to_reen_err", SigErr, 8'd0);
    func_quiesce_ack = 1'b1;
    step();
    step();
    step();
    step();
    chk("to_settle_sel", SigSel, 8'd0);
    step();
    chk("to_test_sel", SigSel, 8'd1);

    func_quiesce_ack = 1'b0;
    step();
    chk("ackdrop_err", SigErr, 8'd1);
    chk("ackdrop_sel", SigSel, 8'd1);
    func_quiesce_ack = 1'b1;

    shift_word(4'b0011);
    chk("pre_triple_so", SigSo, 8'd1);
    functional_data_in = 3'b010;
    ijtag_si = 1'b1;
    ijtag_ce = 1'b1;
    ijtag_se = 1'b1;
    ijtag_ue = 1'b1;
    step();
    ijtag_ce = 1'b0;
    ijtag_se = 1'b0;
    ijtag_ue = 1'b0;
    chk("triple_so", SigSo, 8'd0);
    chk("triple_data", SigData, 8'd6);
    chk("triple_sel", SigSel, 8'd1);

    shift_word(4'b0101);
    update();
    chk("rr_upd_data", SigData, 8'd5);
    step();
    chk("rr_rel_sel", SigSel, 8'd0);
    chk("rr_rel_req", SigReq, 8'd1);
    shift_bit(1'b1);
    update();
    chk("rr_reen_data", SigData, 8'd2);
    chk("rr_reen_req", SigReq, 8'd1);
    step();
    chk("rr_rel3_req", SigReq, 8'd1);
    chk("rr_rel3_sel", SigSel, 8'd0);
    step();
    chk("rr_func_req", SigReq, 8'd0);
    chk("rr_func_err", SigErr, 8'd1);
    step();
    chk("rr_qreq_req", SigReq, 8'd1);
    chk("rr_qreq_err", SigErr, 8'd0);

    step();
    step();
    step();
    step();
    step();
    chk("ar_test_sel", SigSel, 8'd1);
    functional_data_in = 3'b001;
    func_quiesce_ack   = 1'b0;
    capture();
    chk("ar_pre_so", SigSo, 8'd1);
    chk("ar_pre_err", SigErr, 8'd1);
    chk("ar_pre_data", SigData, 8'd2);
    step();
    chk("ar_pre2_sel", SigSel, 8'd1);
    @(negedge ijtag_tck);
    step();
    ijtag_reset = 1'b1;
    #1;
    n_checks = n_checks + 1;
    if (ijtag_select !== 1'b0) begin
      n_errors = n_errors + 1;
      $display("FAIL ar_now_sel: got %0d expected 0", ijtag_select);
    end
    n_checks = n_checks + 1;
    if (func_quiesce_req !== 1'b0) begin
      n_errors = n_errors + 1;
      $display("FAIL ar_now_req: got %0d expected 0", func_quiesce_req);
    end
    n_checks = n_checks + 1;
    if (ijtag_data_out !== 3'b000) begin
      n_errors = n_errors + 1;
      $display("FAIL ar_now_data: got %0d expected 0", ijtag_data_out);
    end
    chk_all_zero("async_reset");
    step();
    ijtag_reset = 1'b0;
    step();
    @(negedge ijtag_tck);
    #1;
    if (n_checks < 12) begin
      n_errors = n_errors + 1;
      $display("FAIL check_count: got %0d expected >= 12", n_checks);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    if (n_errors == 0) begin
      $display("PASS");
    end
    $finish;
  end

endmodule
